// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
//   cond_e     : encoded 4-bit branch condition (12..15 are illegal, never taken)
//   FLAG_*     : bit positions of {O,S,C,Z} in the flag vector
//   sel_width  : width of a counter-select field for n counters (minimum 1)
package bru_pkg;

    typedef enum logic [3:0] {
        COND_ALWAYS = 4'd0,
        COND_Z      = 4'd1,
        COND_NZ     = 4'd2,
        COND_C      = 4'd3,
        COND_BE     = 4'd4,
        COND_A      = 4'd5,
        COND_NC     = 4'd6,
        COND_G      = 4'd7,
        COND_GE     = 4'd8,
        COND_L      = 4'd9,
        COND_LE     = 4'd10,
        COND_LOOP   = 4'd11
    } cond_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_O = 3;

    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned COND_W  = 4;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Branch request / redirect bus between decode, the branch resolve unit and fetch.
//   master : decode side, drives the request and observes ready / results
//   slave  : branch resolve unit, accepts requests and drives redirect / resolve pulses
interface branch_resolve_unit_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned OFF_W  = 8,
    parameter int unsigned SEL_W  = 1
);
    logic              br_valid;
    logic              br_ready;
    logic [3:0]        br_cond;
    logic              br_abs_mode;
    logic [ADDR_W-1:0] br_pc;
    logic [OFF_W-1:0]  br_off;
    logic [ADDR_W-1:0] br_abs;
    logic [SEL_W-1:0]  br_loop_sel;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              resolved;
    logic              illegal_cond;

    modport master (
        output br_valid, br_cond, br_abs_mode, br_pc, br_off, br_abs, br_loop_sel,
        input  br_ready, redirect_valid, redirect_pc, resolved, illegal_cond
    );

    modport slave (
        input  br_valid, br_cond, br_abs_mode, br_pc, br_off, br_abs, br_loop_sel,
        output br_ready, redirect_valid, redirect_pc, resolved, illegal_cond
    );
endinterface

// File: rtl/cond_eval.sv
// Combinational condition decoder: condition code x flags -> taken.
//   cond       : 4-bit condition code (12..15 decode to not taken)
//   flags      : {O,S,C,Z}
//   loop_taken : precomputed LOOP outcome from the selected counter
//   taken_c    : condition holds
module cond_eval
    import bru_pkg::*;
(
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] flags,
    input  logic               loop_taken,
    output logic               taken_c
);
    logic z, c, s, o;

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign s = flags[FLAG_S];
    assign o = flags[FLAG_O];

    always_comb begin
        taken_c = 1'b0;
        case (cond)
            COND_ALWAYS: taken_c = 1'b1;
            COND_Z:      taken_c = z;
            COND_NZ:     taken_c = ~z;
            COND_C:      taken_c = c;
            COND_BE:     taken_c = c | z;
            COND_A:      taken_c = ~c & ~z;
            COND_NC:     taken_c = ~c;
            COND_G:      taken_c = ~z & (s == o);
            COND_GE:     taken_c = (s == o);
            COND_L:      taken_c = (s != o);
            COND_LE:     taken_c = z | (s != o);
            COND_LOOP:   taken_c = loop_taken;
            default:     taken_c = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: flag register, loop counters, target adder and registered
// PC redirect to fetch. One-cycle latency from accept to redirect/resolved pulses.
//   clk, rst_n         : clock, synchronous active-low reset
//   flag_we, flags_in  : ALU flag write {O,S,C,Z}
//   loop_we/sel/wdata  : loop counter load
//   flush              : kills a request presented this cycle
//   flags_out          : current flag register
//   br (slave)         : branch request in, redirect / resolve / illegal pulses out
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter  int unsigned ADDR_W = 16,
    parameter  int unsigned OFF_W  = 8,
    parameter  int unsigned CNT_W  = 16,
    parameter  int unsigned N_LOOP = 2,
    localparam int unsigned SEL_W  = sel_width(N_LOOP)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flag_we,
    input  logic [FLAGS_W-1:0]  flags_in,
    input  logic                loop_we,
    input  logic [SEL_W-1:0]    loop_sel,
    input  logic [CNT_W-1:0]    loop_wdata,
    input  logic                flush,
    output logic [FLAGS_W-1:0]  flags_out,
    branch_resolve_unit_if.slave br
);
    logic [FLAGS_W-1:0] flag_q;
    logic [CNT_W-1:0]   cnt_q [N_LOOP];
    logic               ready_q;
    logic               redirect_valid_q;
    logic [ADDR_W-1:0]  redirect_pc_q;
    logic               resolved_q;
    logic               illegal_q;

    logic [FLAGS_W-1:0] flags_eff_c;
    logic               accept_c;
    logic               is_loop_c;
    logic [CNT_W-1:0]   cur_cnt_c;
    logic               loop_taken_c;
    logic               taken_c;
    logic               redirect_c;
    logic [ADDR_W-1:0]  target_c;

    // Forward a same-cycle flag write into the condition evaluation.
    assign flags_eff_c = flag_we ? flags_in : flag_q;
    assign accept_c    = br.br_valid & ready_q & ~flush;
    assign is_loop_c   = (br.br_cond == COND_LOOP);

    // Counter selected by the LOOP request; out-of-range selects read as zero.
    always_comb begin
        cur_cnt_c = '0;
        for (int unsigned i = 0; i < N_LOOP; i++) begin
            if (br.br_loop_sel == SEL_W'(i)) cur_cnt_c = cnt_q[i];
        end
    end

    // Taken when the post-decrement value is nonzero, i.e. current value > 1.
    assign loop_taken_c = (cur_cnt_c > CNT_W'(1));

    cond_eval u_cond_eval (
        .cond       (br.br_cond),
        .flags      (flags_eff_c),
        .loop_taken (loop_taken_c),
        .taken_c    (taken_c)
    );

    assign redirect_c = accept_c & taken_c;

    // Signed offset is sign-extended by the width cast; the sum wraps modulo 2^ADDR_W.
    assign target_c = br.br_abs_mode ? br.br_abs
                                     : br.br_pc + ADDR_W'($signed(br.br_off));

    // Flag register and output pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_q           <= '0;
            ready_q          <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            resolved_q       <= 1'b0;
            illegal_q        <= 1'b0;
        end else begin
            if (flag_we) flag_q <= flags_in;
            redirect_valid_q <= redirect_c;
            resolved_q       <= accept_c;
            illegal_q        <= accept_c & (br.br_cond >= COND_W'(12));
            if (redirect_c) redirect_pc_q <= target_c;
            // One-cycle bubble while fetch refills after a redirect.
            ready_q          <= ~redirect_c;
        end
    end

    // Loop counters: an explicit load beats a same-cycle LOOP decrement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_LOOP; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_LOOP; i++) begin
                if (loop_we && (loop_sel == SEL_W'(i))) begin
                    cnt_q[i] <= loop_wdata;
                end else if (accept_c && is_loop_c && (br.br_loop_sel == SEL_W'(i))
                             && (cnt_q[i] != '0)) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    assign flags_out         = flag_q;
    assign br.br_ready       = ready_q;
    assign br.redirect_valid = redirect_valid_q;
    assign br.redirect_pc    = redirect_pc_q;
    assign br.resolved       = resolved_q;
    assign br.illegal_cond   = illegal_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the unit.
module tb_branch_resolve_unit;
    import bru_pkg::*;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned OFF_W  = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned N_LOOP = 2;

    logic             clk;
    logic             rst_n;
    logic             flag_we;
    logic [3:0]       flags_in;
    logic             loop_we;
    logic [0:0]       loop_sel;
    logic [CNT_W-1:0] loop_wdata;
    logic             flush;
    logic [3:0]       flags_out;

    branch_resolve_unit_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .SEL_W(1)) bif ();

    branch_resolve_unit #(
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W),
        .CNT_W  (CNT_W),
        .N_LOOP (N_LOOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flag_we    (flag_we),
        .flags_in   (flags_in),
        .loop_we    (loop_we),
        .loop_sel   (loop_sel),
        .loop_wdata (loop_wdata),
        .flush      (flush),
        .flags_out  (flags_out),
        .br         (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [3:0]  m_flags;
    int unsigned m_cnt [N_LOOP];
    bit          m_ready;
    logic [15:0] m_rpc;
    bit          e_rv, e_res, e_ill;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit cond_true(input int cond, input logic [3:0] f, input int unsigned cnt);
        bit z, c, s, o;
        z = f[0]; c = f[1]; s = f[2]; o = f[3];
        case (cond)
            0:  return 1'b1;
            1:  return z;
            2:  return !z;
            3:  return c;
            4:  return c || z;
            5:  return !c && !z;
            6:  return !c;
            7:  return !z && (s == o);
            8:  return s == o;
            9:  return s != o;
            10: return z || (s != o);
            11: return cnt > 1;
            default: return 1'b0;
        endcase
    endfunction

    // Predict the effect of the current inputs, clock once, compare all outputs.
    task automatic step(input string tag);
        logic [3:0]  f;
        bit          acc, tk;
        int          cond, sel, off_i;
        int unsigned c;
        logic [15:0] tgt;
        f     = flag_we ? flags_in : m_flags;
        cond  = int'(bif.br_cond);
        sel   = int'(bif.br_loop_sel);
        c     = m_cnt[sel];
        acc   = bif.br_valid && m_ready && !flush;
        tk    = cond_true(cond, f, c);
        off_i = int'($signed(bif.br_off));
        tgt   = bif.br_abs_mode ? bif.br_abs : 16'((int'(bif.br_pc) + off_i) & 32'hFFFF);
        if (!rst_n) begin
            m_flags = '0;
            for (int i = 0; i < int'(N_LOOP); i++) m_cnt[i] = 0;
            m_ready = 1'b1;
            m_rpc   = '0;
            e_rv = 0; e_res = 0; e_ill = 0;
        end else begin
            m_flags = f;
            if (acc && cond == 11 && c != 0) m_cnt[sel] = c - 1;
            if (loop_we) m_cnt[int'(loop_sel)] = int'(loop_wdata);
            e_res = acc;
            e_ill = acc && cond >= 12;
            e_rv  = acc && tk;
            if (e_rv) m_rpc = tgt;
            m_ready = !e_rv;
        end
        @(posedge clk);
        #1;
        check({tag, "/redirect_valid"}, 32'(bif.redirect_valid), 32'(e_rv));
        check({tag, "/redirect_pc"},    32'(bif.redirect_pc),    32'(m_rpc));
        check({tag, "/resolved"},       32'(bif.resolved),       32'(e_res));
        check({tag, "/illegal_cond"},   32'(bif.illegal_cond),   32'(e_ill));
        check({tag, "/br_ready"},       32'(bif.br_ready),       32'(m_ready));
        check({tag, "/flags_out"},      32'(flags_out),          32'(m_flags));
    endtask

    task automatic quiet();
        rst_n = 1'b1; flag_we = 1'b0; loop_we = 1'b0; flush = 1'b0;
        bif.br_valid = 1'b0;
    endtask

    task automatic req(input logic [3:0] cond, input logic [15:0] pc, input logic [7:0] off);
        bif.br_valid = 1'b1; bif.br_cond = cond; bif.br_abs_mode = 1'b0;
        bif.br_pc = pc; bif.br_off = off;
    endtask

    initial begin
        rst_n = 1'b0; flag_we = 1'b0; flags_in = '0; loop_we = 1'b0; loop_sel = '0;
        loop_wdata = '0; flush = 1'b0;
        bif.br_valid = 1'b0; bif.br_cond = '0; bif.br_abs_mode = 1'b0; bif.br_pc = '0;
        bif.br_off = '0; bif.br_abs = '0; bif.br_loop_sel = '0;
        m_flags = 4'hx; m_ready = 1'b1; m_rpc = '0;
        #2;
        step("reset0");
        step("reset1");
        check("reset_ready", 32'(bif.br_ready), 32'd1);
        check("reset_rv", 32'(bif.redirect_valid), 32'd0);

        // 1: forwarded Z flag, relative target
        quiet(); flag_we = 1'b1; flags_in = 4'b0001; req(4'd1, 16'h0100, 8'h10);
        step("t1");
        check("t1_rv", 32'(bif.redirect_valid), 32'd1);
        check("t1_pc", 32'(bif.redirect_pc), 32'h0110);
        check("t1_bubble", 32'(bif.br_ready), 32'd0);
        quiet(); step("t1_idle");

        // 2: signed comparisons
        flag_we = 1'b1; flags_in = 4'b0000; req(4'd7, 16'h0200, 8'h02);
        step("t2_g");
        check("t2_g_rv", 32'(bif.redirect_valid), 32'd1);
        quiet(); step("t2_idle0");
        flag_we = 1'b1; flags_in = 4'b0100; req(4'd9, 16'h0300, 8'h04);
        step("t2_l");
        check("t2_l_rv", 32'(bif.redirect_valid), 32'd1);
        quiet(); step("t2_idle1");
        flag_we = 1'b1; flags_in = 4'b1100; req(4'd9, 16'h0400, 8'h04);
        step("t2_nl");
        check("t2_nl_res", 32'(bif.resolved), 32'd1);
        check("t2_nl_rv", 32'(bif.redirect_valid), 32'd0);
        quiet(); step("t2_idle2");

        // 3: wrapping relative target and absolute target
        req(4'd0, 16'h0004, 8'hF8);
        step("t3_wrap");
        check("t3_wrap_pc", 32'(bif.redirect_pc), 32'hFFFC);
        quiet(); step("t3_idle0");
        req(4'd0, 16'h0004, 8'hF8); bif.br_abs_mode = 1'b1; bif.br_abs = 16'h1234;
        step("t3_abs");
        check("t3_abs_pc", 32'(bif.redirect_pc), 32'h1234);
        quiet(); step("t3_idle1");

        // 4: loop counter 3 -> taken, taken, not taken, not taken
        loop_we = 1'b1; loop_sel = 1'b0; loop_wdata = 16'd3;
        step("t4_load");
        quiet();
        for (int k = 0; k < 4; k++) begin
            req(4'd11, 16'h0500, 8'hF0); bif.br_loop_sel = 1'b0;
            step("t4_loop");
            check("t4_loop_rv", 32'(bif.redirect_valid), (k < 2) ? 32'd1 : 32'd0);
            check("t4_loop_res", 32'(bif.resolved), 32'd1);
            quiet(); step("t4_idle");
        end

        // 5: flushed LOOP leaves the counter alone; illegal condition
        loop_we = 1'b1; loop_sel = 1'b0; loop_wdata = 16'd2;
        step("t5_load");
        quiet();
        req(4'd11, 16'h0600, 8'h08); flush = 1'b1;
        step("t5_flush");
        check("t5_flush_res", 32'(bif.resolved), 32'd0);
        flush = 1'b0;
        step("t5_loop");
        check("t5_loop_rv", 32'(bif.redirect_valid), 32'd1);
        quiet(); step("t5_idle0");
        req(4'd13, 16'h0700, 8'h08);
        step("t5_illegal");
        check("t5_ill", 32'(bif.illegal_cond), 32'd1);
        check("t5_ill_rv", 32'(bif.redirect_valid), 32'd0);
        quiet(); step("t5_idle1");

        // 6: reset right after a taken accept
        flag_we = 1'b1; flags_in = 4'b1010; req(4'd0, 16'h0800, 8'h20);
        step("t6_taken");
        quiet(); rst_n = 1'b0;
        step("t6_reset");
        check("t6_rv", 32'(bif.redirect_valid), 32'd0);
        check("t6_flags", 32'(flags_out), 32'd0);
        check("t6_ready", 32'(bif.br_ready), 32'd1);
        quiet(); step("t6_idle");

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst_n            = ($urandom_range(0, 99) != 0);
            flag_we          = ($urandom_range(0, 3) == 0);
            flags_in         = 4'($urandom);
            loop_we          = ($urandom_range(0, 5) == 0);
            loop_sel         = 1'($urandom);
            loop_wdata       = 16'($urandom_range(0, 4));
            flush            = ($urandom_range(0, 7) == 0);
            bif.br_valid     = ($urandom_range(0, 2) != 0);
            bif.br_cond      = ($urandom_range(0, 2) == 0) ? 4'd11 : 4'($urandom);
            bif.br_abs_mode  = 1'($urandom);
            bif.br_pc        = 16'($urandom);
            bif.br_off       = 8'($urandom);
            bif.br_abs       = 16'($urandom);
            bif.br_loop_sel  = 1'($urandom);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
